free_list: RTL and testbench

Physical-register free list for the dual-issue rename stage: a circular buffer of unallocated physical register numbers. Each cycle it supplies up to two new destination PRFs (`prf_rd_new`) to the rename map table. It reclaims up to two stale PRFs from the commit stage. It keeps a committed read pointer so that a pipeline flush (`recover`) restores exactly the non-committed allocations. PRF 0 is the permanent zero/initial mapping and is never handed out or reclaimed.

---
 rtl/free_list.sv | 149 ++++++++++++++
 tb/tb_free_list.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//
// Physical-register free list for a dual-issue rename stage. A circular
// buffer holds unallocated physical register numbers. Up to two PRFs are
// offered per cycle to the rename map table, and up to two stale PRFs are
// reclaimed from commit per cycle. A committed read pointer lets a flush
// (recover) return every allocation made since the last commit. PRF 0 is
// the permanent initial mapping and is never handed out or reclaimed.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   recover                    flush: rewind speculative allocations
//   alloc_req_0/1              rename slot needs a destination PRF
//   alloc_prf_0/1              PRF offered to slot 0 / slot 1 (combinational)
//   alloc_ready                at least two entries allocatable
//   commit_valid_0/1           retiring instruction valid
//   commit_wr_0/1              retiring instruction wrote a register
//   commit_stale_0/1           stale PRF of the retiring instruction
//   free_count                 number of entries currently allocatable
// ---------------------------------------------------------------------------
module free_list #(
    parameter int PRF_NUM = 64,
    parameter int PRF_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recover,
    input  logic             alloc_req_0,
    input  logic             alloc_req_1,
    output logic [PRF_W-1:0] alloc_prf_0,
    output logic [PRF_W-1:0] alloc_prf_1,
    output logic             alloc_ready,
    input  logic             commit_valid_0,
    input  logic             commit_valid_1,
    input  logic             commit_wr_0,
    input  logic             commit_wr_1,
    input  logic [PRF_W-1:0] commit_stale_0,
    input  logic [PRF_W-1:0] commit_stale_1,
    output logic [PRF_W:0]   free_count
);

    logic [PRF_W-1:0] mem [PRF_NUM];

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PRF_W:0] spec_rd;
    logic [PRF_W:0] cmt_rd;
    logic [PRF_W:0] wr;

    logic [PRF_W:0] spec_rd_p1;
    logic [PRF_W:0] wr_p1;
    logic [PRF_W:0] spec_next;
    logic [PRF_W:0] cmt_next;
    logic [PRF_W:0] wr_next;
    logic [PRF_W:0] occupancy_next;

    logic [1:0] alloc_cnt;
    logic [1:0] cmt_cnt;
    logic [1:0] free_cnt;

    logic             cmt_0;
    logic             cmt_1;
    logic             free_0;
    logic             free_1;
    logic             wen_first;
    logic             wen_second;
    logic [PRF_W-1:0] first_val;

    assign spec_rd_p1 = spec_rd + 1'b1;
    assign wr_p1      = wr + 1'b1;

    assign free_count  = wr - spec_rd;
    assign alloc_ready = (free_count >= (PRF_W+1)'(2));

    // Slot 1 takes the entry after slot 0 only when slot 0 consumes one.
    assign alloc_prf_0 = mem[spec_rd[PRF_W-1:0]];
    assign alloc_prf_1 = alloc_req_0 ? mem[spec_rd_p1[PRF_W-1:0]]
                                     : mem[spec_rd[PRF_W-1:0]];

    assign cmt_0  = commit_valid_0 && commit_wr_0;
    assign cmt_1  = commit_valid_1 && commit_wr_1;
    // A stale PRF of 0 is the initial mapping and is silently dropped.
    assign free_0 = cmt_0 && (commit_stale_0 != '0);
    assign free_1 = cmt_1 && (commit_stale_1 != '0);

    assign alloc_cnt = {1'b0, alloc_req_0} + {1'b0, alloc_req_1};
    assign cmt_cnt   = {1'b0, cmt_0} + {1'b0, cmt_1};
    assign free_cnt  = {1'b0, free_0} + {1'b0, free_1};

    assign cmt_next = cmt_rd + {{(PRF_W-1){1'b0}}, cmt_cnt};
    assign wr_next  = wr + {{(PRF_W-1){1'b0}}, free_cnt};

    // Freed PRFs are packed: whichever slot frees first lands at wr, and
    // a second free (only possible from slot 1) lands at wr+1.
    assign wen_first  = free_0 || free_1;
    assign wen_second = free_0 && free_1;
    assign first_val  = free_0 ? commit_stale_0 : commit_stale_1;

    // Recover rewinds to the committed pointer including same-cycle commits;
    // allocation is ignored while recovering or when fewer than two are free.
    always_comb begin
        spec_next = spec_rd;
        if (recover) begin
            spec_next = cmt_next;
        end else if (alloc_ready) begin
            spec_next = spec_rd + {{(PRF_W-1){1'b0}}, alloc_cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_rd <= '0;
            cmt_rd  <= '0;
            wr      <= (PRF_W+1)'(PRF_NUM - 1);
        end else begin
            spec_rd <= spec_next;
            cmt_rd  <= cmt_next;
            wr      <= wr_next;
        end
    end

    // Reset fills the buffer with PRFs 1..PRF_NUM-1; the last slot sits
    // beyond wr, holds no free PRF, and is overwritten by the first free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRF_NUM - 1; i++) begin
                mem[i] <= PRF_W'(i + 1);
            end
            mem[PRF_NUM-1] <= '0;
        end else begin
            if (wen_first) begin
                mem[wr[PRF_W-1:0]] <= first_val;
            end
            if (wen_second) begin
                mem[wr_p1[PRF_W-1:0]] <= commit_stale_1;
            end
        end
    end

    // Entries between cmt_rd and wr can never exceed the non-zero PRFs.
    assign occupancy_next = wr_next - cmt_next;

    always @(posedge clk) begin
        if (!rst) begin
            assert (occupancy_next <= (PRF_W+1)'(PRF_NUM - 1));
        end
    end

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
//
// Directed testbench for free_list: reset state, single/dual allocation,
// compacted frees with stale PRF 0, stall at free_count = 1, recover with a
// same-cycle commit, mid-operation reset, and a long wrap-around run with a
// uniqueness scoreboard and a hand-derived offer sequence.
// ---------------------------------------------------------------------------
module tb_free_list;

    logic       clk;
    logic       rst;
    logic       recover;
    logic       alloc_req_0;
    logic       alloc_req_1;
    logic [5:0] alloc_prf_0;
    logic [5:0] alloc_prf_1;
    logic       alloc_ready;
    logic       commit_valid_0;
    logic       commit_valid_1;
    logic       commit_wr_0;
    logic       commit_wr_1;
    logic [5:0] commit_stale_0;
    logic [5:0] commit_stale_1;
    logic [6:0] free_count;

    int total;
    int bad;

    logic       in_use [64];
    logic [5:0] p0;
    logic [5:0] p1;
    logic [5:0] prev0;
    logic [5:0] prev1;
    int         n;

    free_list #(.PRF_NUM(64), .PRF_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .recover        (recover),
        .alloc_req_0    (alloc_req_0),
        .alloc_req_1    (alloc_req_1),
        .alloc_prf_0    (alloc_prf_0),
        .alloc_prf_1    (alloc_prf_1),
        .alloc_ready    (alloc_ready),
        .commit_valid_0 (commit_valid_0),
        .commit_valid_1 (commit_valid_1),
        .commit_wr_0    (commit_wr_0),
        .commit_wr_1    (commit_wr_1),
        .commit_stale_0 (commit_stale_0),
        .commit_stale_1 (commit_stale_1),
        .free_count     (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic       r0,
        input logic       r1,
        input logic       rec,
        input logic       cv0,
        input logic       cw0,
        input logic [5:0] s0,
        input logic       cv1,
        input logic       cw1,
        input logic [5:0] s1
    );
        alloc_req_0    = r0;
        alloc_req_1    = r1;
        recover        = rec;
        commit_valid_0 = cv0;
        commit_wr_0    = cw0;
        commit_stale_0 = s0;
        commit_valid_1 = cv1;
        commit_wr_1    = cw1;
        commit_stale_1 = s1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) in_use[i] = 1'b0;

        // Reset, then observe the offer with alloc_req_0 high and low.
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_free_count", free_count, 63);
        checkOutput("rst_prf0", alloc_prf_0, 1);
        checkOutput("rst_prf1_req0", alloc_prf_1, 2);
        checkOutput("rst_ready", alloc_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_prf1_noreq0", alloc_prf_1, 1);
        tick();
        checkOutput("idle_free_count", free_count, 63);

        // Dual allocate, then slot 1 only.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dual_prf0", alloc_prf_0, 1);
        checkOutput("dual_prf1", alloc_prf_1, 2);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s1only_free_count", free_count, 61);
        checkOutput("s1only_prf0", alloc_prf_0, 3);
        checkOutput("s1only_prf1", alloc_prf_1, 3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_alloc3_free_count", free_count, 60);
        checkOutput("after_alloc3_prf0", alloc_prf_0, 4);

        // Dual commit, stale {0,5}: only PRF 5 is freed.
        applyStimulus(0, 0, 0, 1, 1, 0, 1, 1, 5);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("free_stale0_free_count", free_count, 61);
        checkOutput("free_stale0_prf0", alloc_prf_0, 4);

        // Allocate two per cycle down to free_count = 1.
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("drain_prf0", alloc_prf_0, 4 + 2 * k);
            checkOutput("drain_prf1", alloc_prf_1, 5 + 2 * k);
            checkOutput("drain_ready", alloc_ready, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("low_free_count", free_count, 1);
        checkOutput("low_ready", alloc_ready, 0);
        checkOutput("low_prf0", alloc_prf_0, 5);

        // Requests while not ready must be ignored.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checkOutput("stall_free_count", free_count, 1);
            checkOutput("stall_prf0", alloc_prf_0, 5);
        end

        // One free of PRF 7; ready rises only in the following cycle.
        applyStimulus(1, 1, 0, 1, 1, 7, 0, 0, 0);
        checkOutput("free7_same_cycle_ready", alloc_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("free7_ready", alloc_ready, 1);
        checkOutput("free7_free_count", free_count, 2);
        checkOutput("free7_prf0", alloc_prf_0, 5);

        // Reset in the middle of operation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst2_free_count", free_count, 63);
        checkOutput("rst2_prf0", alloc_prf_0, 1);
        checkOutput("rst2_ready", alloc_ready, 1);

        // Allocate 1..4, then recover with a same-cycle commit (stale 0).
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rec_a_prf0", alloc_prf_0, 1);
        checkOutput("rec_a_prf1", alloc_prf_1, 2);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rec_b_prf0", alloc_prf_0, 3);
        checkOutput("rec_b_prf1", alloc_prf_1, 4);
        tick();
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("rec_pre_free_count", free_count, 59);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rec_prf0", alloc_prf_0, 2);
        checkOutput("rec_free_count", free_count, 62);
        checkOutput("rec_ready", alloc_ready, 1);

        // Wrap-around: dual allocate and dual free of the previous pair.
        n = 0;
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        p0 = alloc_prf_0;
        p1 = alloc_prf_1;
        checkOutput("wrap_seq0", p0, 2);
        checkOutput("wrap_seq1", p1, 3);
        in_use[p0] = 1'b1;
        in_use[p1] = 1'b1;
        prev0 = p0;
        prev1 = p1;
        n = 2;
        tick();
        for (int c = 1; c <= 80; c++) begin
            applyStimulus(1, 1, 0, 1, 1, prev0, 1, 1, prev1);
            checkOutput("wrap_free_count", free_count, 60);
            p0 = alloc_prf_0;
            p1 = alloc_prf_1;
            checkOutput("wrap_seq0", p0, 2 + (n % 62));
            checkOutput("wrap_seq1", p1, 2 + ((n + 1) % 62));
            checkOutput("wrap_unique0", in_use[p0], 0);
            in_use[p0] = 1'b1;
            checkOutput("wrap_unique1", in_use[p1], 0);
            in_use[p1] = 1'b1;
            in_use[prev0] = 1'b0;
            in_use[prev1] = 1'b0;
            prev0 = p0;
            prev1 = p1;
            n = n + 2;
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_end_free_count", free_count, 60);
        checkOutput("wrap_end_ready", alloc_ready, 1);
        checkOutput("wrap_end_prf0", alloc_prf_0, 2 + (n % 62));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
